// File: rtl/mioc_dram_sequencer.sv
// MIOC DRAM timing sequencer and Z80/6801 bus arbiter.
// Drives RAS_N/MUX/CASx_N for Z80 access, refresh and DMA cycles.
module mioc_dram_sequencer #(
   parameter int unsigned RAS_TO_MUX = 1,
   parameter int unsigned MUX_TO_CAS = 1,
   parameter int unsigned CAS_WIDTH  = 2,
   parameter int unsigned PRECHARGE  = 2
) (
   input  logic B_PHI,
   input  logic RST,
   input  logic BMREQ_N,
   input  logic BRFSH_N,
   input  logic BRD_N,
   input  logic N_BWR,
   input  logic BA15,
   input  logic DMA_N,
   input  logic DMA_STB,
   input  logic DMA_BANK,
   input  logic BUSAK_N,
   output logic BUSRQ_N,
   output logic DMA_GNT,
   output logic RAS_N,
   output logic MUX,
   output logic CAS1_N,
   output logic CAS2_N,
   output logic DONE
);

   typedef enum logic [2:0] {
      D_IDLE, D_RAS, D_MUXS, D_CAS, D_PRE
   } dram_e;

   typedef enum logic [1:0] {
      B_Z80, B_REQ, B_DMA, B_REL
   } bus_e;

   // Phase counters hold "cycles left minus one"; refresh spans three phases.
   localparam logic [5:0] L_R2M = 6'(RAS_TO_MUX - 1);
   localparam logic [5:0] L_M2C = 6'(MUX_TO_CAS - 1);
   localparam logic [5:0] L_CW  = 6'(CAS_WIDTH - 1);
   localparam logic [5:0] L_PRE = 6'(PRECHARGE - 1);
   localparam logic [5:0] L_RF  =
      6'(RAS_TO_MUX + MUX_TO_CAS + CAS_WIDTH - 1);

   dram_e      state_q, state_d;
   bus_e       bus_q, bus_d;
   logic [5:0] cnt_q, cnt_d;
   logic       bank_q, bank_d;
   logic       rfsh_q, rfsh_d;
   logic       armed_q, armed_d;

   logic       ras_n_q, ras_n_d;
   logic       mux_q, mux_d;
   logic       cas1_n_q, cas1_n_d;
   logic       cas2_n_q, cas2_n_d;
   logic       done_q, done_d;
   logic       busrq_n_q, busrq_n_d;
   logic       dma_gnt_q, dma_gnt_d;

   logic       idle;
   logic       z80_go;
   logic       z80_rf;
   logic       z80_acc;
   logic       dma_acc;

   assign idle    = (state_q == D_IDLE);
   assign z80_go  = idle && (bus_q == B_Z80) && armed_q && !BMREQ_N;
   assign z80_rf  = z80_go && !BRFSH_N;
   assign z80_acc = z80_go && BRFSH_N && (!BRD_N || !N_BWR);
   assign dma_acc = idle && (bus_q == B_DMA) && DMA_STB;

   // DRAM cycle FSM: launch decode, phase sequencing and re-arm tracking.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bank_d  = bank_q;
      rfsh_d  = rfsh_q;
      armed_d = armed_q;
      if (BMREQ_N) armed_d = 1'b1;
      unique case (state_q)
         D_IDLE: begin
            unique case (1'b1)
               z80_rf: begin
                  state_d = D_RAS;
                  cnt_d   = L_RF;
                  rfsh_d  = 1'b1;
                  armed_d = 1'b0;
               end
               z80_acc: begin
                  state_d = D_RAS;
                  cnt_d   = L_R2M;
                  rfsh_d  = 1'b0;
                  bank_d  = BA15;
                  armed_d = 1'b0;
               end
               dma_acc: begin
                  state_d = D_RAS;
                  cnt_d   = L_R2M;
                  rfsh_d  = 1'b0;
                  bank_d  = DMA_BANK;
               end
               default: ;
            endcase
         end
         D_RAS: begin
            if (cnt_q == 6'd0) begin
               state_d = rfsh_q ? D_PRE : D_MUXS;
               cnt_d   = rfsh_q ? L_PRE : L_M2C;
            end else begin
               cnt_d = cnt_q - 6'd1;
            end
         end
         D_MUXS: begin
            if (cnt_q == 6'd0) begin
               state_d = D_CAS;
               cnt_d   = L_CW;
            end else begin
               cnt_d = cnt_q - 6'd1;
            end
         end
         D_CAS: begin
            if (cnt_q == 6'd0) begin
               state_d = D_PRE;
               cnt_d   = L_PRE;
            end else begin
               cnt_d = cnt_q - 6'd1;
            end
         end
         D_PRE: begin
            if (cnt_q == 6'd0) state_d = D_IDLE;
            else cnt_d = cnt_q - 6'd1;
         end
         default: state_d = D_IDLE;
      endcase
   end

   // Bus ownership FSM: BUSRQ_N/BUSAK_N handshake around DMA sessions.
   always_comb begin
      bus_d = bus_q;
      unique case (bus_q)
         B_Z80: if (!DMA_N) bus_d = B_REQ;
         B_REQ: begin
            if (DMA_N) bus_d = B_REL;
            else if (!BUSAK_N && idle) bus_d = B_DMA;
         end
         B_DMA: if (DMA_N && idle) bus_d = B_REL;
         B_REL: if (BUSAK_N) bus_d = B_Z80;
         default: bus_d = B_Z80;
      endcase
   end

   // Pin values decoded from the current states, registered next edge.
   always_comb begin
      ras_n_d   = !(state_q == D_RAS || state_q == D_MUXS ||
                    state_q == D_CAS);
      mux_d     = !rfsh_q && (state_q == D_MUXS || state_q == D_CAS);
      cas1_n_d  = !(state_q == D_CAS && !bank_q);
      cas2_n_d  = !(state_q == D_CAS && bank_q);
      done_d    = (state_q == D_PRE) && (cnt_q == L_PRE) && !rfsh_q;
      busrq_n_d = !(bus_q == B_REQ || bus_q == B_DMA);
      dma_gnt_d = (bus_q == B_DMA);
   end

   // State registers.
   always_ff @(posedge B_PHI or posedge RST) begin
      if (RST) begin
         state_q <= D_IDLE;
         bus_q   <= B_Z80;
         cnt_q   <= 6'd0;
         bank_q  <= 1'b0;
         rfsh_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         bus_q   <= bus_d;
         cnt_q   <= cnt_d;
         bank_q  <= bank_d;
         rfsh_q  <= rfsh_d;
         armed_q <= armed_d;
      end
   end

   // Output registers.
   always_ff @(posedge B_PHI or posedge RST) begin
      if (RST) begin
         ras_n_q   <= 1'b1;
         mux_q     <= 1'b0;
         cas1_n_q  <= 1'b1;
         cas2_n_q  <= 1'b1;
         done_q    <= 1'b0;
         busrq_n_q <= 1'b1;
         dma_gnt_q <= 1'b0;
      end else begin
         ras_n_q   <= ras_n_d;
         mux_q     <= mux_d;
         cas1_n_q  <= cas1_n_d;
         cas2_n_q  <= cas2_n_d;
         done_q    <= done_d;
         busrq_n_q <= busrq_n_d;
         dma_gnt_q <= dma_gnt_d;
      end
   end

   assign RAS_N   = ras_n_q;
   assign MUX     = mux_q;
   assign CAS1_N  = cas1_n_q;
   assign CAS2_N  = cas2_n_q;
   assign DONE    = done_q;
   assign BUSRQ_N = busrq_n_q;
   assign DMA_GNT = dma_gnt_q;

endmodule

// File: tb/tb_mioc_dram_sequencer.sv
// Directed bench for mioc_dram_sequencer.
// Vectors: {RAS_N,MUX,CAS1_N,CAS2_N,DONE} and {BUSRQ_N,DMA_GNT}.
module tb_mioc_dram_sequencer;

   logic B_PHI = 1'b0;
   logic RST;
   logic BMREQ_N, BRFSH_N, BRD_N, N_BWR, BA15;
   logic DMA_N, DMA_STB, DMA_BANK, BUSAK_N;
   logic BUSRQ_N, DMA_GNT;
   logic RAS_N, MUX, CAS1_N, CAS2_N, DONE;

   int total = 0;
   int bad = 0;

   always #5 B_PHI = ~B_PHI;

   mioc_dram_sequencer dut (
      .B_PHI(B_PHI), .RST(RST),
      .BMREQ_N(BMREQ_N), .BRFSH_N(BRFSH_N),
      .BRD_N(BRD_N), .N_BWR(N_BWR), .BA15(BA15),
      .DMA_N(DMA_N), .DMA_STB(DMA_STB),
      .DMA_BANK(DMA_BANK), .BUSAK_N(BUSAK_N),
      .BUSRQ_N(BUSRQ_N), .DMA_GNT(DMA_GNT),
      .RAS_N(RAS_N), .MUX(MUX),
      .CAS1_N(CAS1_N), .CAS2_N(CAS2_N), .DONE(DONE)
   );

   task automatic step();
      @(posedge B_PHI);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] dv();
      return {3'b000, RAS_N, MUX, CAS1_N, CAS2_N, DONE};
   endfunction

   function automatic logic [7:0] bv();
      return {6'b0, BUSRQ_N, DMA_GNT};
   endfunction

   localparam logic [7:0] IDL = 8'b000_10110;

   initial begin
      logic [7:0] acc_tab [8];
      logic [7:0] rf_tab [8];
      logic [7:0] dma_tab [7];
      logic [7:0] arb_tab [7];
      int falls;
      int dones;
      logic prev;

      acc_tab = '{8'b000_10110, 8'b000_00110, 8'b000_01110,
                  8'b000_01010, 8'b000_01010, 8'b000_10111,
                  8'b000_10110, 8'b000_10110};
      rf_tab  = '{8'b000_10110, 8'b000_00110, 8'b000_00110,
                  8'b000_00110, 8'b000_00110, 8'b000_10110,
                  8'b000_10110, 8'b000_10110};
      dma_tab = '{8'b000_10110, 8'b000_00110, 8'b000_01110,
                  8'b000_01100, 8'b000_01100, 8'b000_10111,
                  8'b000_10110};
      arb_tab = '{8'b10, 8'b00, 8'b00, 8'b00, 8'b00, 8'b00, 8'b01};

      RST = 1'b1;
      BMREQ_N = 1'b1; BRFSH_N = 1'b1; BRD_N = 1'b1;
      N_BWR = 1'b1; BA15 = 1'b0;
      DMA_N = 1'b1; DMA_STB = 1'b0; DMA_BANK = 1'b0;
      BUSAK_N = 1'b1;
      step(); step();
      chk("reset_dram", dv(), IDL);
      chk("reset_bus", bv(), 8'b10);
      RST = 1'b0;
      step(); step();

      // Z80 read, bank 0, sampled at edge 0
      BMREQ_N = 1'b0; BRD_N = 1'b0;
      step();
      BMREQ_N = 1'b1; BRD_N = 1'b1;
      for (int c = 0; c < 8; c++) begin
         chk($sformatf("rd_c%0d", c), dv(), acc_tab[c]);
         step();
      end

      // Refresh
      BMREQ_N = 1'b0; BRFSH_N = 1'b0;
      step();
      BMREQ_N = 1'b1; BRFSH_N = 1'b1;
      for (int c = 0; c < 8; c++) begin
         chk($sformatf("rf_c%0d", c), dv(), rf_tab[c]);
         step();
      end

      // Held write request: one access only, then re-arm
      BMREQ_N = 1'b0; N_BWR = 1'b0;
      falls = 0; dones = 0; prev = RAS_N;
      for (int c = 0; c < 20; c++) begin
         step();
         if (!RAS_N && prev) falls++;
         if (DONE) dones++;
         prev = RAS_N;
      end
      chk("hold_ras_falls", 8'(falls), 8'd1);
      chk("hold_dones", 8'(dones), 8'd1);
      BMREQ_N = 1'b1;
      step();
      BMREQ_N = 1'b0;
      step();
      chk("rearm_c0", dv(), IDL);
      step();
      chk("rearm_c1", {7'b0, RAS_N}, 8'd0);
      BMREQ_N = 1'b1; N_BWR = 1'b1;
      repeat (8) step();

      // DMA session
      DMA_N = 1'b0;
      step();
      chk("dma_c0_bus", bv(), 8'b10);
      step();
      chk("dma_c1_bus", bv(), 8'b00);
      step();
      BUSAK_N = 1'b0;
      step();
      chk("dma_c3_bus", bv(), 8'b00);
      step();
      chk("dma_c4_bus", bv(), 8'b01);
      DMA_STB = 1'b1; DMA_BANK = 1'b1;
      BMREQ_N = 1'b0; BRD_N = 1'b0;
      step();
      DMA_STB = 1'b0;
      for (int c = 5; c < 12; c++) begin
         chk($sformatf("dma_c%0d", c), dv(), dma_tab[c-5]);
         if (c == 7) DMA_STB = 1'b1;
         if (c == 8) DMA_STB = 1'b0;
         if (c == 9) begin
            BMREQ_N = 1'b1; BRD_N = 1'b1;
         end
         if (c == 11) DMA_N = 1'b1;
         step();
      end
      chk("dma_c12_bus", bv(), 8'b01);
      chk("dma_c12_dropped", dv(), IDL);
      step();
      chk("dma_c13_bus", bv(), 8'b10);
      BUSAK_N = 1'b1;
      step();
      BMREQ_N = 1'b0; BRD_N = 1'b0; BA15 = 1'b1;
      step();
      BMREQ_N = 1'b1; BRD_N = 1'b1; BA15 = 1'b0;
      step();
      chk("z80_after_dma_c1", dv(), 8'b000_00110);
      step(); step();
      chk("z80_after_dma_c3", dv(), 8'b000_01100);
      repeat (5) step();

      // DMA request during a Z80 access
      BMREQ_N = 1'b0; BRD_N = 1'b0;
      step();
      BMREQ_N = 1'b1; BRD_N = 1'b1;
      step();
      DMA_N = 1'b0; BUSAK_N = 1'b0;
      step();
      for (int c = 2; c < 9; c++) begin
         chk($sformatf("arb_c%0d", c), bv(), arb_tab[c-2]);
         if (c == 5) chk("arb_done_c5", dv(), 8'b000_10111);
         if (c < 8) step();
      end
      DMA_N = 1'b1;
      step(); step();
      chk("arb_rel", bv(), 8'b10);
      BUSAK_N = 1'b1;
      step(); step();

      // Reset in the middle of an access
      BMREQ_N = 1'b0; BRD_N = 1'b0;
      step(); step(); step(); step();
      chk("mid_c3_cas", dv(), 8'b000_01010);
      RST = 1'b1;
      #1;
      chk("mid_rst_dram", dv(), IDL);
      chk("mid_rst_bus", bv(), 8'b10);
      step();
      RST = 1'b0;
      falls = 0; dones = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (!RAS_N) falls++;
         if (DONE) dones++;
      end
      chk("mid_no_relaunch", 8'(falls), 8'd0);
      chk("mid_no_done", 8'(dones), 8'd0);
      BMREQ_N = 1'b1;
      step();
      BMREQ_N = 1'b0;
      step(); step();
      chk("mid_relaunch", {7'b0, RAS_N}, 8'd0);
      BMREQ_N = 1'b1; BRD_N = 1'b1;
      repeat (8) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
